// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the RISC datapath control unit: opcodes, function
// select encodings, sequencer state codes, IR field positions and the
// control word carried from the decoder to the top.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_DEC  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BRZ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_DJNZ = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] FS_PASSA = 4'd0;
  localparam logic [3:0] FS_ADD   = 4'd2;
  localparam logic [3:0] FS_SUB   = 4'd5;

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EX0   = 3'd2;
  localparam logic [2:0] ST_EX1   = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam int IR_OP_HI  = 15;
  localparam int IR_DR_HI  = 11;
  localparam int IR_SA_HI  = 8;
  localparam int IR_SB_HI  = 5;
  localparam int IR_IMM_HI = 2;

  typedef struct packed {
    logic       il;
    logic       pi;
    logic       pl;
    logic       ma;
    logic       mb;
    logic       md;
    logic       rw;
    logic       mw;
    logic [3:0] fs;
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_undef_op(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational control-word decoder: maps sequencer state, latched IR fields
// and the memory handshake onto the datapath controls.
module seq_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [2:0]     state,
  input  logic [OPW-1:0] op,
  input  logic [2:0]     dr,
  input  logic [2:0]     sa,
  input  logic [2:0]     sb,
  input  logic           mem_ready,
  input  logic           mem_to,
  input  logic           z,
  input  logic           z_q,
  output ctrl_t          ctrl
);

  // Control word per state; EX0 routes the register addresses straight from IR.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.il = 1'b1;
        ctrl.pi = 1'b1;
      end
      ST_EX0: begin
        ctrl.da = dr;
        ctrl.aa = sa;
        ctrl.ba = sb;
        case (op)
          OP_NOP, OP_HALT: ;
          OP_MOV:  begin ctrl.fs = FS_PASSA; ctrl.rw = 1'b1; end
          OP_ADD:  begin ctrl.fs = FS_ADD;   ctrl.rw = 1'b1; end
          OP_SUB:  begin ctrl.fs = FS_SUB;   ctrl.rw = 1'b1; end
          OP_ADDI: begin ctrl.mb = 1'b1; ctrl.fs = FS_ADD; ctrl.rw = 1'b1; end
          OP_DEC:  begin ctrl.ma = 1'b1; ctrl.fs = FS_PASSA; ctrl.rw = 1'b1; end
          OP_LD:   begin ctrl.md = 1'b1; ctrl.rw = mem_ready; end
          // Write strobe is withdrawn only on the abort cycle of a timed-out store.
          OP_ST:   ctrl.mw = mem_ready | ~mem_to;
          OP_BRZ:  begin ctrl.fs = FS_PASSA; ctrl.pl = z; end
          OP_JMP:  ctrl.pl = 1'b1;
          OP_DJNZ: begin ctrl.ma = 1'b1; ctrl.fs = FS_PASSA; ctrl.rw = 1'b1; end
          default: ;
        endcase
      end
      ST_EX1: ctrl.pl = ~z_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit for the 16-bit RISC datapath. Holds the state
// register, the IR, the memory-wait counter and the registered status flags.
//
// state | meaning
// RST   | first cycle after reset release, all controls idle
// FETCH | load IR from instruction memory, increment PC
// EX0   | execute; LD/ST stay here until mem_ready or timeout
// EX1   | DJNZ second cycle, branch on captured zero flag
// HALT  | terminal, only reset leaves
module datapath_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPW         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_in,
  input  logic        z,
  input  logic        mem_ready,
  output logic        il,
  output logic        pi,
  output logic        pl,
  output logic        ma,
  output logic        mb,
  output logic        md,
  output logic        rw,
  output logic        mw,
  output logic [3:0]  fs,
  output logic [2:0]  da,
  output logic [2:0]  aa,
  output logic [2:0]  ba,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [7:0] TO_LIMIT = 8'(MEM_TIMEOUT);

  logic [2:0]     state, state_nxt;
  logic [15:0]    ir_q;
  logic [7:0]     to_cnt;
  logic           z_q, halted_q, illegal_q, bus_err_q;
  logic [OPW-1:0] op;
  logic           in_ex0, mem_op, mem_to;
  logic           unused_imm;
  ctrl_t          ctrl;

  assign op         = ir_q[IR_OP_HI -: OPW];
  assign in_ex0     = (state == ST_EX0);
  assign mem_op     = is_mem_op(op);
  assign mem_to     = (to_cnt == TO_LIMIT);
  // The immediate goes to the datapath via the B-mux, not through this block.
  assign unused_imm = ^ir_q[IR_IMM_HI:0];

  seq_decode #(.OPW(OPW)) u_decode (
    .state     (state),
    .op        (op),
    .dr        (ir_q[IR_DR_HI -: 3]),
    .sa        (ir_q[IR_SA_HI -: 3]),
    .sb        (ir_q[IR_SB_HI -: 3]),
    .mem_ready (mem_ready),
    .mem_to    (mem_to),
    .z         (z),
    .z_q       (z_q),
    .ctrl      (ctrl)
  );

  // Next-state selection; memory ops leave EX0 on completion or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_EX0;
      ST_EX0: begin
        if (op == OP_HALT)                        state_nxt = ST_HALT;
        else if (op == OP_DJNZ)                   state_nxt = ST_EX1;
        else if (!mem_op || mem_ready || mem_to)  state_nxt = ST_FETCH;
      end
      ST_EX1:   state_nxt = ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RST;
    endcase
  end

  // State, IR and memory-wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RST;
      ir_q   <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH) begin
        ir_q   <= ir_in;
        to_cnt <= '0;
      end else if (in_ex0 && mem_op && !mem_ready && !mem_to) begin
        to_cnt <= to_cnt + 8'd1;
      end
    end
  end

  // Registered status flags; the pulses appear in the cycle after their cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_q       <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (in_ex0 && (op == OP_DJNZ)) z_q <= z;
      halted_q  <= halted_q | (in_ex0 && (op == OP_HALT));
      illegal_q <= in_ex0 && is_undef_op(op);
      bus_err_q <= in_ex0 && mem_op && mem_to && !mem_ready;
    end
  end

  assign il      = ctrl.il;
  assign pi      = ctrl.pi;
  assign pl      = ctrl.pl;
  assign ma      = ctrl.ma;
  assign mb      = ctrl.mb;
  assign md      = ctrl.md;
  assign rw      = ctrl.rw;
  assign mw      = ctrl.mw;
  assign fs      = ctrl.fs;
  assign da      = ctrl.da;
  assign aa      = ctrl.aa;
  assign ba      = ctrl.ba;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed scenarios plus a random instruction
// stream, each cycle compared against an instruction-level reference model.
module tb_datapath_sequencer;

  localparam int MEM_TO = 15;

  logic        clk, reset;
  logic [15:0] ir_in;
  logic        z, mem_ready;
  logic        il, pi, pl, ma, mb, md, rw, mw;
  logic [3:0]  fs;
  logic [2:0]  da, aa, ba;
  logic        halted, illegal, bus_err;
  logic [23:0] obs;

  int checks = 0;
  int errors = 0;

  // Model flags visible in the current cycle.
  logic halted_m, ill_m, be_m;

  datapath_sequencer #(.MEM_TIMEOUT(MEM_TO), .OPW(4)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .z(z), .mem_ready(mem_ready),
    .il(il), .pi(pi), .pl(pl), .ma(ma), .mb(mb), .md(md), .rw(rw), .mw(mw),
    .fs(fs), .da(da), .aa(aa), .ba(ba),
    .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  assign obs = {il, pi, pl, ma, mb, md, rw, mw, fs, da, aa, ba, halted, illegal, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pk(input logic il_e, pi_e, pl_e, ma_e, mb_e, md_e, rw_e, mw_e,
                                     input logic [3:0] fs_e, input logic [2:0] da_e, aa_e, ba_e,
                                     input logic h_e, ill_e, be_e);
    return {il_e, pi_e, pl_e, ma_e, mb_e, md_e, rw_e, mw_e, fs_e, da_e, aa_e, ba_e, h_e, ill_e, be_e};
  endfunction

  // Expected EX0 controls of an instruction, straight from the opcode table.
  function automatic logic [23:0] ex0_model(input logic [15:0] instr, input logic zv,
                                            input logic mr, input logic timed,
                                            input logic h, input logic ill, input logic be);
    logic pl_e = 0, ma_e = 0, mb_e = 0, md_e = 0, rw_e = 0, mw_e = 0;
    logic [3:0] fs_e = 4'd0;
    case (instr[15:12])
      4'h1: rw_e = 1;
      4'h2: begin fs_e = 4'd2; rw_e = 1; end
      4'h3: begin fs_e = 4'd5; rw_e = 1; end
      4'h4: begin mb_e = 1; fs_e = 4'd2; rw_e = 1; end
      4'h5: begin ma_e = 1; rw_e = 1; end
      4'h6: begin md_e = 1; rw_e = mr; end
      4'h7: mw_e = !timed;
      4'h8: pl_e = zv;
      4'h9: pl_e = 1;
      4'hA: begin ma_e = 1; rw_e = 1; end
      default: ;
    endcase
    return pk(0, 0, pl_e, ma_e, mb_e, md_e, rw_e, mw_e, fs_e,
              instr[11:9], instr[8:6], instr[5:3], h, ill, be);
  endfunction

  task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, compare 1ns later.
  task automatic step(input logic [15:0] ir_v, input logic z_v, input logic mr_v,
                      input logic [23:0] e, input string tag);
    @(negedge clk);
    ir_in = ir_v; z = z_v; mem_ready = mr_v;
    #1;
    chk(tag, obs, e);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    halted_m = 0; ill_m = 0; be_m = 0;
    #1;
    chk({tag, ":rst_state"}, obs, 24'h0);
  endtask

  // Full instruction: FETCH, then EX cycles. ready_after = mem_ready-low cycles.
  task automatic run_instr(input logic [15:0] instr, input int ready_after,
                           input logic zv, input string tag);
    logic [3:0] op;
    logic mr, timed;
    op = instr[15:12];
    step(instr, 1'($urandom), 1'($urandom),
         pk(1, 1, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 3'd0, 3'd0, halted_m, ill_m, be_m),
         {tag, ":fetch"});
    ill_m = 0; be_m = 0;
    if (op == 4'h6 || op == 4'h7) begin
      for (int k = 0; k <= MEM_TO; k++) begin
        mr    = (k >= ready_after);
        timed = (k == MEM_TO) && !mr;
        step(16'($urandom), 1'($urandom), mr,
             ex0_model(instr, 1'b0, mr, timed, halted_m, 0, 0), {tag, ":memwait"});
        if (mr || timed) begin
          be_m = timed;
          break;
        end
      end
    end else begin
      step(16'($urandom), zv, 1'($urandom),
           ex0_model(instr, zv, 1'b0, 1'b0, halted_m, 0, 0), {tag, ":ex0"});
      if (op >= 4'hB && op <= 4'hE) ill_m = 1;
      if (op == 4'hF) halted_m = 1;
      if (op == 4'hA)
        step(16'($urandom), 1'($urandom), 1'($urandom),
             pk(0, 0, !zv, 0, 0, 0, 0, 0, 4'd0, 3'd0, 3'd0, 3'd0, halted_m, 0, 0),
             {tag, ":ex1"});
    end
  endtask

  initial begin
    logic [15:0] instr;
    int ra;
    reset = 1'b1; ir_in = '0; z = 0; mem_ready = 0;
    halted_m = 0; ill_m = 0; be_m = 0;

    repeat (2) @(negedge clk);
    #1 chk("reset_hold", obs, 24'h0);
    release_reset("init");

    // DEC R5 <= R1 - 1
    run_instr(16'h5A40, 0, 1'b0, "dec");
    // DJNZ with nonzero result then zero result
    run_instr(16'hA2C8, 0, 1'b0, "djnz_nz");
    run_instr(16'hA2C8, 0, 1'b1, "djnz_z");
    // LD with three wait cycles
    run_instr(16'h6A51, 3, 1'b0, "ld_wait3");
    // ST that never completes -> timeout, bus_err on following FETCH
    run_instr(16'h7E38, 1000, 1'b0, "st_timeout");
    // Undefined opcode, then a plain op whose FETCH shows the illegal pulse
    run_instr(16'hC123, 0, 1'b0, "undef_c");
    run_instr(16'h2456, 0, 1'b0, "add_after_undef");
    run_instr(16'h9000, 0, 1'b0, "jmp");
    run_instr(16'h8040, 0, 1'b1, "brz_taken");
    run_instr(16'h8040, 0, 1'b0, "brz_not_taken");
    run_instr(16'h6000, 0, 1'b0, "ld_immediate");
    run_instr(16'h6000, MEM_TO, 1'b0, "ld_ready_at_limit");

    // Random instruction stream, no HALT
    for (int n = 0; n < 80; n++) begin
      instr = 16'($urandom);
      instr[15:12] = 4'($urandom_range(0, 14));
      ra = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 4);
      run_instr(instr, ra, 1'($urandom), "rand");
    end

    // Reset during a store wait: mw must drop without waiting for a clock
    run_instr(16'h0000, 0, 1'b0, "nop");
    step(16'h7111, 1'b0, 1'b0,
         pk(1, 1, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 3'd0, 3'd0, halted_m, ill_m, be_m), "st_rst:fetch");
    for (int k = 0; k < 3; k++)
      step(16'h0, 1'b0, 1'b0, ex0_model(16'h7111, 0, 0, 0, 0, 0, 0), "st_rst:wait");
    #2 reset = 1'b1;
    #1 chk("st_rst:mw_drop", obs, 24'h0);
    @(negedge clk);
    #1 chk("st_rst:hold", obs, 24'h0);
    release_reset("st_rst");
    run_instr(16'h1280, 0, 1'b0, "mov_after_rst");

    // HALT, then idle for 20 cycles
    run_instr(16'hF000, 0, 1'b0, "halt");
    for (int k = 0; k < 20; k++)
      step(16'($urandom), 1'($urandom), 1'($urandom),
           pk(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 3'd0, 3'd0, 3'd0, 1, 0, 0), "halt_idle");
    #2 reset = 1'b1;
    #1 chk("halt_reset", obs, 24'h0);
    release_reset("post_halt");
    run_instr(16'h3ABC, 0, 1'b0, "sub_after_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
